// File: rtl/riscv_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operation encodings
// (equal to the RV32M funct3 field) and the control FSM state type.
package riscv_muldiv_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } state_e;

endpackage

// File: rtl/riscv_muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath.
// Multiply: acc = {partial_hi, multiplier}; add the multiplicand into the high
// half when the multiplier LSB is set, then shift right by one.
// Divide: acc = {remainder, dividend/quotient}; shift left by one and keep the
// trial subtraction only when it does not go negative (restoring division).
module riscv_muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0]       sum;
    logic [XLEN:0]       trial;
    logic [XLEN:0]       diff;
    logic [2*XLEN-1:0]   mul_next;
    logic [2*XLEN-1:0]   div_next;

    // Compute both candidate iterations and pick by operation class
    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
        mul_next = acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

        // Remainder stays below the divisor, so trial < 2*divisor and a
        // non-negative difference always fits back into XLEN bits.
        trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff  = trial - {1'b0, operand};
        if (!diff[XLEN]) begin
            div_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            div_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end

        acc_next = is_div ? div_next : mul_next;
    end

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes.
// Operands are converted to magnitudes at acceptance, XLEN radix-2 iterations
// run in CALC, and signs/half selection/special cases are applied in FIX.
// Optional build macro RISCV_MULDIV_EARLY_OUT_EN: divide-by-zero (any op) and
// signed-overflow requests skip CALC and go straight to FIX.
module riscv_muldiv
    import riscv_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned CNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic              bzero_q, bzero_d;
    logic              ovf_q, ovf_d;

    // Acceptance-time decode of the incoming request
    logic              a_signed, b_signed, a_neg, b_neg, bzero_in, ovf_in;
    logic [XLEN-1:0]   abs_a, abs_b;

    // Fix-up datapath
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem, quot_s, rem_s, fix_result;

    riscv_muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div   (op_q[2]),
        .acc      (acc_q),
        .operand  (opnd_q),
        .acc_next (acc_step)
    );

    // Decode operand signedness and magnitudes for a request being offered
    always_comb begin
        a_signed = (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
        b_signed = (op == MULH) || (op == DIV) || (op == REM);
        a_neg    = a_signed & a[XLEN-1];
        b_neg    = b_signed & b[XLEN-1];
        abs_a    = a_neg ? -a : a;
        abs_b    = b_neg ? -b : b;
        bzero_in = (b == '0);
        ovf_in   = ((op == DIV) || (op == REM)) && (a == MinNeg) && (&b);
    end

    // Sign correction, half/quotient/remainder selection and special cases
    always_comb begin
        prod   = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot   = acc_q[XLEN-1:0];
        rem    = acc_q[2*XLEN-1:XLEN];
        quot_s = (neg_a_q ^ neg_b_q) ? -quot : quot;
        rem_s  = neg_a_q ? -rem : rem;
        fix_result = '0;
        unique case (op_q)
            MUL:                 fix_result = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_result = prod[2*XLEN-1:XLEN];
            DIV:  fix_result = bzero_q ? '1  : (ovf_q ? a_q : quot_s);
            DIVU: fix_result = bzero_q ? '1  : quot;
            REM:  fix_result = bzero_q ? a_q : (ovf_q ? '0 : rem_s);
            REMU: fix_result = bzero_q ? a_q : rem;
            default: fix_result = '0;
        endcase
        // The accumulator is not iterated on the early-out path
        if (!op_q[2] && bzero_q) begin
            fix_result = '0;
        end
    end

    // FSM next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_d      = a_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        bzero_d  = bzero_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d    = op;
                    a_d     = a;
                    acc_d   = {{XLEN{1'b0}}, abs_a};
                    opnd_d  = abs_b;
                    neg_a_d = a_neg;
                    neg_b_d = b_neg;
                    bzero_d = bzero_in;
                    ovf_d   = ovf_in;
                    cnt_d   = '0;
                    state_d = StCalc;
`ifdef RISCV_MULDIV_EARLY_OUT_EN
                    if (bzero_in || ovf_in) begin
                        state_d = StFix;
                    end
`endif
                end
            end
            StCalc: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(XLEN - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = fix_result;
                state_d  = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= MUL;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            bzero_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_q      <= a_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            bzero_q  <= bzero_d;
            ovf_q    <= ovf_d;
        end
    end

    // Handshake and status outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        result    = result_q;
    end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv (XLEN=32): directed RV32M cases,
// special cases, backpressure, mid-operation reset and random operations
// compared against a 64-bit arithmetic reference model.
module tb_riscv_muldiv;

    localparam int unsigned XLEN = 32;
    localparam int NormLat = 33;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    riscv_muldiv #(
        .XLEN (XLEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint     sx;
        longint     sy;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (o)
            3'd0: begin p = ux * uy;          return p[31:0];  end
            3'd1: begin p = 64'(sx * sy);     return p[63:32]; end
            3'd2: begin p = 64'(sx * longint'(uy)); return p[63:32]; end
            3'd3: begin p = ux * uy;          return p[63:32]; end
            3'd4: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                p = 64'(sx / sy);
                return p[31:0];
            end
            3'd5: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                p = ux / uy;
                return p[31:0];
            end
            3'd6: begin
                if (y == 32'h0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                p = 64'(sx % sy);
                return p[31:0];
            end
            default: begin
                if (y == 32'h0) return x;
                p = ux % uy;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Offer a request, confirm acceptance, scramble inputs, await and check result
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        logic [31:0] exp;
        int n;
        exp = ref_model(o, x, y);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
        check_eq({tag, ".busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, ".latency"}, 32'(n), 32'(NormLat));
        check_eq({tag, ".result"}, result, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, ".back_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check_eq("rst.in_ready", 32'(in_ready), 32'd1);
        check_eq("rst.out_valid", 32'(out_valid), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        check_eq("rst.result", result, 32'd0);
        reset = 1'b0;

        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD);
        check_eq("mul.const", result, 32'hFFFF_FFEB);
        run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div", 3'd4, 32'hFFFF_FFE7, 32'd4);
        check_eq("div.const", result, 32'hFFFF_FFFA);
        run_op("rem", 3'd6, 32'hFFFF_FFE7, 32'd4);
        run_op("divu", 3'd5, 32'd100, 32'd7);
        run_op("remu", 3'd7, 32'd100, 32'd7);
        run_op("divu0", 3'd5, 32'd25, 32'd0);
        run_op("rem0", 3'd6, 32'd25, 32'd0);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Backpressure: hold DONE while a new request is offered
        @(negedge clk);
        op = 3'd5; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp.latency", 32'(n), 32'(NormLat));
        op = 3'd0; a = 32'd6; b = 32'd7; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp.result", result, 32'd14);
            check_eq("bp.in_ready", 32'(in_ready), 32'd0);
            check_eq("bp.out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("bp.idle_ready", 32'(in_ready), 32'd1);
        check_eq("bp.idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bp.accepted", 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp.new_latency", 32'(n), 32'(NormLat));
        check_eq("bp.new_result", result, 32'd42);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset at CALC iteration 10
        @(negedge clk);
        op = 3'd4; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("mid.busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("mid.in_ready", 32'(in_ready), 32'd1);
        check_eq("mid.out_valid", 32'(out_valid), 32'd0);
        check_eq("mid.result", result, 32'd0);
        check_eq("mid.busy0", 32'(busy), 32'd0);
        run_op("post_rst", 3'd0, 32'd3, 32'd5);
        check_eq("post_rst.const", result, 32'd15);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            run_op("rnd", 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
